wb_write_arbiter: RTL
=====================

// Module: wb_write_arbiter
// PURPOSE
//  Writer side of the register-file write port: owns Reg_Write/Reg_WID/Reg_WData.
//  Merges in-order MEM/WB writebacks with late results from multi-cycle units (mult/div, load miss).
//  Late results are buffered in a small FIFO and retired in acceptance order.
//  Exports a pending-write mask for the hazard unit.
// PARAMETERS
//  DATA_W     32  write data width
//  ADDR_W     5   register ID width
//  NUM_REGS   16  implemented registers; IDs >= NUM_REGS are out of range
//  FIFO_DEPTH 2   multi-cycle result buffer entries (>=1)
// PORTS
//  clk        in  1         single clock; all state on posedge
//  reset      in  1         asynchronous, active-low reset
//  pipe_we    in  1         MEM/WB write request; highest priority, never stalled
//  pipe_wid   in  ADDR_W    MEM/WB destination ID
//  pipe_wdata in  DATA_W    MEM/WB write data
//  mc_valid   in  1         multi-cycle result valid
//  mc_wid     in  ADDR_W    multi-cycle destination ID
//  mc_wdata   in  DATA_W    multi-cycle result data
//  mc_ready   out 1         FIFO can accept; transfer = mc_valid & mc_ready
//  Reg_Write  out 1         register-file write enable (registered)
//  Reg_WID    out ADDR_W    register-file write ID (registered)
//  Reg_WData  out DATA_W    register-file write data (registered)
//  pend_mask  out NUM_REGS  bit i = valid queued write to register i
//  err_oob    out 1         1-cycle pulse: out-of-range ID dropped
// BEHAVIOUR
//  Reset (async, reset=0): Reg_Write=0, Reg_WID=0, Reg_WData=0, FIFO empty, pend_mask=0,
//   err_oob=0, mc_ready=0 while asserted. Mid-operation reset discards all queued writes.
//  Latency: request selected in cycle N drives Reg_* in cycle N+1 (regfile writes at negedge of N+1).
//  At most one write per cycle. Priority: pipe_we > FIFO head > direct mc bypass.
//  mc_ready = (count < FIFO_DEPTH) & reset deasserted; depends on count only, not on pipe_we.
//   Full: mc_ready=0 even if a dequeue occurs the same cycle.
//  Accepted mc entry: if FIFO empty and pipe_we=0, bypass to output (latency 1); else enqueue.
//  Dequeue: when pipe_we=0 and FIFO non-empty, pop the head. Order: strict acceptance order.
//  WAW kill: when pipe_we=1, every valid FIFO entry with wid==pipe_wid is invalidated.
//   An mc entry accepted the same cycle with wid==pipe_wid is dropped.
//   The pipeline write is the younger one.
//   A popped invalid entry gives Reg_Write=0 for that cycle.
//  Idle/killed cycles: Reg_Write=0, and Reg_WID/Reg_WData HOLD their last values.
//   Required because the regfile read bypass compares Reg_WID without qualifying on Reg_Write.
//   Held values always equal the register contents. Reset 0/0 matches the R0 reset value.
//  OOB: pipe or mc ID >= NUM_REGS is never written or queued; err_oob pulses the next cycle.
//   An OOB mc transfer still completes its handshake.
//  pend_mask: derived from registered FIFO state. It updates the cycle after enqueue, kill or pop.
//  Counter and pointers wrap modulo FIFO_DEPTH; count never exceeds FIFO_DEPTH.
// TESTING
//  1 Release reset; pipe_we=1, wid=3, data=0x1234 -> next cycle Reg_Write=1, WID=3, WData=0x1234.
//    Following idle cycle: Reg_Write=0, WID=3 and WData=0x1234 held.
//  2 FIFO empty; mc_valid, wid=5, data=0xA5 -> mc_ready=1 -> next cycle write 5/0xA5; pend_mask stays 0.
//  3 pipe_we=1 for 4 cycles; mc offers wids 6,7,8 -> 6,7 accepted, mc_ready=0, pend_mask[6]=pend_mask[7]=1.
//    After the pipe idles: writes 6, 7, 8 in order on consecutive cycles.
//  4 Queue wid 9 data 0x99 while pipe is busy; pipe writes 9/0x77 -> 0x99 never written.
//    pend_mask[9]=0 next cycle; the popped slot shows Reg_Write=0.
//  5 mc wid=20 -> accepted, err_oob=1 for 1 cycle, Reg_Write=0, no FIFO entry.
//  6 Two entries queued; assert reset mid-cycle -> Reg_*=0 and mc_ready=0 immediately.
//    After release: pend_mask=0 and no stale writes.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//   Owns the register-file write port. MEM/WB writebacks always win the port;
//   results from multi-cycle units (mult/div, load miss) are buffered in a
//   small in-order FIFO and retired whenever the pipeline leaves the port idle.
//   A pending-write mask, built from the queued entries, feeds the hazard unit.
//   Reg_WID/Reg_WData only change on a real write, so the regfile read bypass
//   can compare Reg_WID without qualifying it on Reg_Write.
module wb_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_REGS   = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,        // asynchronous, active-low
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_wid,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              mc_valid,
  input  logic [ADDR_W-1:0] mc_wid,
  input  logic [DATA_W-1:0] mc_wdata,
  output logic              mc_ready,
  output logic              Reg_Write,
  output logic [ADDR_W-1:0] Reg_WID,
  output logic [DATA_W-1:0] Reg_WData,
  output logic [NUM_REGS-1:0] pend_mask,
  output logic              err_oob
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // One extra bit so an ADDR_W-wide ID can be compared against NUM_REGS
  // even when NUM_REGS == 2**ADDR_W.
  localparam logic [ADDR_W:0]  NUM_REGS_C = NUM_REGS[ADDR_W:0];
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR_C = PTR_W'(FIFO_DEPTH - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic              valid_q [FIFO_DEPTH];
  logic              valid_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] wid_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] data_q  [FIFO_DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] reg_wid_q,   reg_wid_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              err_oob_q,   err_oob_d;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic pipe_oob;
  logic mc_oob;
  logic fifo_empty;
  logic fifo_full;
  logic mc_xfer;
  logic pipe_kill;
  logic mc_same_wid;
  logic do_pop;
  logic do_bypass;
  logic do_push;
  logic head_valid;
  logic [ADDR_W-1:0] head_wid;
  logic [DATA_W-1:0] head_data;

  assign pipe_oob   = {1'b0, pipe_wid} >= NUM_REGS_C;
  assign mc_oob     = {1'b0, mc_wid}   >= NUM_REGS_C;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);

  // Ready depends only on occupancy (never on pipe_we), so the multi-cycle
  // units see a stable handshake; a same-cycle pop does not reopen a full FIFO.
  assign mc_ready = ~fifo_full & reset;
  assign mc_xfer  = mc_valid & mc_ready;

  // The pipeline write is younger than anything queued for the same register,
  // so an in-range pipeline write cancels older queued writes to that ID.
  assign pipe_kill   = pipe_we & ~pipe_oob;
  assign mc_same_wid = pipe_kill & (mc_wid == pipe_wid);

  // The pipeline consumes the port slot even when its ID is out of range.
  assign do_pop    = ~pipe_we & ~fifo_empty;
  assign do_bypass = ~pipe_we &  fifo_empty & mc_xfer & ~mc_oob;
  assign do_push   = mc_xfer & ~mc_oob & ~do_bypass & ~mc_same_wid;

  assign head_valid = valid_q[rd_ptr_q];
  assign head_wid   = wid_q[rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];

  // ---------------------------------------------------------------------
  // Port selection: pipeline > FIFO head > direct bypass; hold on idle
  // ---------------------------------------------------------------------
  always_comb begin
    reg_write_d = 1'b0;
    reg_wid_d   = reg_wid_q;
    reg_wdata_d = reg_wdata_q;
    if (pipe_we) begin
      if (!pipe_oob) begin
        reg_write_d = 1'b1;
        reg_wid_d   = pipe_wid;
        reg_wdata_d = pipe_wdata;
      end
    end else if (!fifo_empty) begin
      // A killed head still occupies its slot; it just writes nothing.
      if (head_valid) begin
        reg_write_d = 1'b1;
        reg_wid_d   = head_wid;
        reg_wdata_d = head_data;
      end
    end else if (do_bypass) begin
      reg_write_d = 1'b1;
      reg_wid_d   = mc_wid;
      reg_wdata_d = mc_wdata;
    end
  end

  // Flag any out-of-range ID that was presented and dropped this cycle.
  always_comb begin
    err_oob_d = (pipe_we & pipe_oob) | (mc_xfer & mc_oob);
  end

  // ---------------------------------------------------------------------
  // FIFO pointers and occupancy (modulo FIFO_DEPTH)
  // ---------------------------------------------------------------------
  // Advance read/write pointers and track occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR_C) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR_C) ? '0 : wr_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Per-entry valid bit: set on push, cleared on pop or WAW kill.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_comb begin
        valid_d[gi] = valid_q[gi];
        if (pipe_kill && valid_q[gi] && (wid_q[gi] == pipe_wid)) begin
          valid_d[gi] = 1'b0;
        end
        if (do_pop && (rd_ptr_q == PTR_W'(gi))) begin
          valid_d[gi] = 1'b0;
        end
        if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
          valid_d[gi] = 1'b1;
        end
      end

      // Valid bits are the only FIFO state reset needs to clear.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_q[gi] <= 1'b0;
        end else begin
          valid_q[gi] <= valid_d[gi];
        end
      end
    end
  endgenerate

  // Payload storage: written only on push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      wid_q[wr_ptr_q]  <= mc_wid;
      data_q[wr_ptr_q] <= mc_wdata;
    end
  end

  // Pointer, count, output and error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      reg_write_q <= 1'b0;
      reg_wid_q   <= '0;
      reg_wdata_q <= '0;
      err_oob_q   <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      reg_write_q <= reg_write_d;
      reg_wid_q   <= reg_wid_d;
      reg_wdata_q <= reg_wdata_d;
      err_oob_q   <= err_oob_d;
    end
  end

  // ---------------------------------------------------------------------
  // Pending-write mask from registered FIFO contents
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
      // Register gi is pending if any valid queued entry targets it.
      always_comb begin
        pend_mask[gi] = 1'b0;
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          if (valid_q[e] && (wid_q[e] == ADDR_W'(gi))) begin
            pend_mask[gi] = 1'b1;
          end
        end
      end
    end
  endgenerate

  assign Reg_Write = reg_write_q;
  assign Reg_WID   = reg_wid_q;
  assign Reg_WData = reg_wdata_q;
  assign err_oob   = err_oob_q;

endmodule
